// File: rtl/scan_pkg.sv
// Scan-path encodings and types used by the scannable register slices.
package scan_pkg;

  localparam logic SCAN_FUNCTIONAL = 1'b0;
  localparam logic SCAN_SHIFT      = 1'b1;

  typedef logic scan_en_t;

endpackage

// File: rtl/scan_mux2_bit.sv
// Single-bit scan input mux: picks the scan source in shift mode, else the functional bit.
module scan_mux2_bit
  import scan_pkg::*;
(
  input  logic test,
  input  logic d,
  input  logic sdi,
  output logic m
);

  scan_en_t scan_en;

  assign scan_en = test;
  // An unknown scan enable merges both sources rather than masking the X.
  assign m = (scan_en == SCAN_SHIFT) ? sdi : d;

endmodule

// File: rtl/scan_mux2.sv
// Scan mux plus scan flip-flop slice; multi-bit slices form a shift register in scan mode.
module scan_mux2
  import scan_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] D,
  input  logic             SDI,
  input  logic             Test,
  output logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] Q,
  output logic             SDO
);

  logic [WIDTH-1:0] scan_src;

  if (WIDTH < 1) begin : g_width_check
    $error("scan_mux2: WIDTH must be >= 1");
  end

  // Bit 0 takes the serial input; higher bits take their lower neighbour, giving a left shift.
  if (WIDTH == 1) begin : g_src_single
    assign scan_src = SDI;
  end else begin : g_src_chain
    assign scan_src = {Q[WIDTH-2:0], SDI};
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    scan_mux2_bit u_bit (
      .test (Test),
      .d    (D[i]),
      .sdi  (scan_src[i]),
      .m    (M[i])
    );
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Q <= '0;
    end else begin
      Q <= M;
    end
  end

  assign SDO = Q[WIDTH-1];

  a_reset_clears : assert property (@(posedge Clock) Reset |=> (Q == '0));
  a_functional_path : assert property (@(posedge Clock) (Test == SCAN_FUNCTIONAL) |-> (M == D));

endmodule

// File: tb/tb_scan_mux2.sv
// Directed and randomised checks of scan_mux2 at WIDTH=1 and WIDTH=4.
module tb_scan_mux2;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic       r1, d1, s1, t1, m1, q1, o1;
  logic       r4, s4, t4, o4;
  logic [3:0] d4, m4, q4;

  int checks = 0;
  int errors = 0;

  scan_mux2 #(.WIDTH(1)) u_w1 (
    .Clock(Clock), .Reset(r1), .D(d1), .SDI(s1), .Test(t1),
    .M(m1), .Q(q1), .SDO(o1)
  );

  scan_mux2 #(.WIDTH(4)) u_w4 (
    .Clock(Clock), .Reset(r4), .D(d4), .SDI(s4), .Test(t4),
    .M(m4), .Q(q4), .SDO(o4)
  );

  typedef struct {
    logic r, d, s, t;
    logic exp_m, exp_q;
  } vec1_t;

  vec1_t tab[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive the 4-bit slice, check M before the edge, then Q/SDO after it.
  task automatic step4(input string nm, input logic r, input logic [3:0] d, input logic s,
                       input logic t, input logic [3:0] exp_m, input logic [3:0] exp_q);
    @(negedge Clock);
    r4 = r; d4 = d; s4 = s; t4 = t;
    #1;
    chk({nm, " m4"}, {28'd0, m4}, {28'd0, exp_m});
    @(posedge Clock);
    #1;
    chk({nm, " q4"}, {28'd0, q4}, {28'd0, exp_q});
    chk({nm, " sdo4"}, {31'd0, o4}, {31'd0, exp_q[3]});
  endtask

  initial begin
    logic       mq1, em1;
    logic [3:0] mq4, em4;

    //            r     d     s     t     m     q
    tab[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tab[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tab[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tab[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tab[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tab[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tab[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tab[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tab[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tab[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tab[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tab[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tab[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tab[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    r1 = 1'b1; d1 = 1'b0; s1 = 1'b0; t1 = 1'b0;
    r4 = 1'b1; d4 = 4'h0; s4 = 1'b0; t4 = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge Clock);
      r1 = tab[i].r; d1 = tab[i].d; s1 = tab[i].s; t1 = tab[i].t;
      #1;
      chk($sformatf("w1 vec%0d m", i), {31'd0, m1}, {31'd0, tab[i].exp_m});
      @(posedge Clock);
      #1;
      chk($sformatf("w1 vec%0d q", i), {31'd0, q1}, {31'd0, tab[i].exp_q});
      chk($sformatf("w1 vec%0d sdo", i), {31'd0, o1}, {31'd0, tab[i].exp_q});
    end

    // Shift 1,0,1,1 into the 4-bit slice, then a functional load.
    step4("shift0", 1'b0, 4'h0, 1'b1, 1'b1, 4'b0001, 4'b0001);
    step4("shift1", 1'b0, 4'h0, 1'b0, 1'b1, 4'b0010, 4'b0010);
    step4("shift2", 1'b0, 4'h0, 1'b1, 1'b1, 4'b0101, 4'b0101);
    step4("shift3", 1'b0, 4'h0, 1'b1, 1'b1, 4'b1011, 4'b1011);
    step4("func",   1'b0, 4'b0110, 1'b1, 1'b0, 4'b0110, 4'b0110);

    // Reset beats an active scan shift; M then reflects the cleared register.
    step4("loadf",  1'b0, 4'hF, 1'b0, 1'b0, 4'hF, 4'hF);
    step4("rstwin", 1'b1, 4'hF, 1'b1, 1'b1, 4'hF, 4'h0);
    step4("rstrel", 1'b0, 4'hF, 1'b1, 1'b1, 4'b0001, 4'b0001);

    mq1 = q1 === 1'b1 ? 1'b1 : 1'b0;
    mq1 = 1'b0;
    mq4 = 4'b0001;
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clock);
      r1 = ($urandom_range(0, 31) == 0);
      d1 = 1'($urandom_range(0, 1));
      s1 = 1'($urandom_range(0, 1));
      t1 = 1'($urandom_range(0, 1));
      r4 = ($urandom_range(0, 31) == 0);
      d4 = 4'($urandom_range(0, 15));
      s4 = 1'($urandom_range(0, 1));
      t4 = 1'($urandom_range(0, 1));
      #1;
      em1 = t1 ? s1 : d1;
      em4 = t4 ? {mq4[2:0], s4} : d4;
      chk("rnd m1", {31'd0, m1}, {31'd0, em1});
      chk("rnd m4", {28'd0, m4}, {28'd0, em4});
      @(posedge Clock);
      #1;
      mq1 = r1 ? 1'b0 : em1;
      mq4 = r4 ? 4'h0 : em4;
      chk("rnd q1", {31'd0, q1}, {31'd0, mq1});
      chk("rnd sdo1", {31'd0, o1}, {31'd0, mq1});
      chk("rnd q4", {28'd0, q4}, {28'd0, mq4});
      chk("rnd sdo4", {31'd0, o4}, {31'd0, mq4[3]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_mux2.md
Name: scan_mux2

Overview:
- Scan-path input multiplexer with a scan flip-flop, used in front of every scannable register bit in the datapath.
- Functional mode (Test=0): the functional data D is selected.
- Scan mode (Test=1): the serial scan input SDI is selected, and for multi-bit instances the register shifts.
- The combinational mux output M is always available; the registered value Q and the scan-out SDO allow instances to be chained.

Parameters:
- WIDTH, 1, number of bits in the mux/register slice (must be >= 1).

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- D  input  WIDTH  functional data input.
- SDI  input  1  serial scan data in.
- Test  input  1  scan enable: 0 = functional (D), 1 = scan (SDI).
- M  output  WIDTH  combinational mux output.
- Q  output  WIDTH  registered copy of M.
- SDO  output  1  scan data out, equal to Q[WIDTH-1].

Behaviour:
- Mux output M is purely combinational, with zero latency and no clock dependence.
  - Test=0: M = D.
  - Test=1, WIDTH=1: M = SDI.
  - Test=1, WIDTH>1: M = {Q[WIDTH-2:0], SDI}, i.e. a shift-left by one with SDI entering bit 0.
- Register update on each rising Clock edge:
  - If Reset=1: Q <= 0.
  - Otherwise: Q <= M.
- Reset:
  - Reset has priority over Test and D.
  - Reset does not directly force M. When WIDTH>1 and Test=1, M reflects the cleared Q after the reset edge.
  - After reset: Q = 0 and SDO = 0.
- Latency:
  - M follows D, SDI or Test within the same delta cycle.
  - Q and SDO reflect M one clock after it is sampled.
- Test toggling:
  - A change of Test immediately reselects M.
  - The next edge captures the newly selected source. No glitch filtering or synchronisation is applied to Test.
- Shift behaviour (WIDTH>1, Test=1):
  - After N edges, SDI bit k (0-based arrival order) sits at Q[N-1-k].
  - The first SDI bit reaches SDO after WIDTH edges.
- X propagation:
  - An unknown on Test yields unknown M where D and the scan source differ.
  - No X-masking is applied.
- Simulation-only assertions:
  - WIDTH >= 1 is checked at elaboration.
  - After any clock edge with Reset=1, Q == 0.
  - With Test=0, M == D.

Decomposition:
- Shared package scan_pkg:
  - localparam SCAN_FUNCTIONAL = 1'b0 and SCAN_SHIFT = 1'b1, for the Test encodings.
  - A typedef for the scan-enable signal, reused by other scannable blocks.
- One sub-module is natural: scan_mux2_bit, a single-bit combinational 2:1 mux (Test ? SDI_bit : D_bit).
  - It is instantiated WIDTH times via a generate loop.
  - The per-bit scan source is SDI for bit 0 and Q[i-1] for bit i>0.
  - The register and the SDO tap live in scan_mux2.

Test Plan:
1. WIDTH=1, Reset held for 2 edges, then released with D=0, SDI=0, Test=0 -> Q=0, SDO=0, M=0. Then D=1 -> M=1 immediately, Q=1 after next edge. Then D=0 -> M=0.
2. WIDTH=1, Test=1 with D=0, SDI=0 -> M=0. Then SDI=1 -> M=1 and Q=1 next edge. Then SDI=0 -> M=0. Then Test=0 with D=0 -> M=0. Covers the full functional/scan sequence.
3. WIDTH=1, Test=1, SDI=0, D=1 -> M=0 (D ignored). Then Test=0 -> M=1 (SDI ignored).
4. WIDTH=4, Test=1, shift SDI sequence 1,0,1,1 over 4 edges -> Q=4'b1011 and SDO=1. Then Test=0, D=4'b0110, one edge -> Q=4'b0110, SDO=0.
5. WIDTH=4, Q=4'hF loaded via D, then Reset=1 with Test=1, SDI=1 for one edge -> Q=0 (reset wins). Release reset, next edge -> Q=4'b0001.
6. Random D/SDI/Test for 1000 cycles against a reference model of the mux plus register -> M, Q and SDO match every cycle.
